uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set FIFO entries; power of two, minimum 2.
REQ-002 Parameter AW, default $clog2(DEPTH), SHALL set pointer width; not overridden by instantiators.
REQ-003 ser_ck  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  byte from the deserializer, valid while rx_available=1.
REQ-006 rx_available  in  1  level from the deserializer: byte pending.
REQ-007 rx_ack  out  1  one-cycle pulse to the deserializer's rd_data input: byte consumed.
REQ-008 dout  out  8  head-of-FIFO byte (first-word fall-through).
REQ-009 dout_valid  out  1  FIFO not empty.
REQ-010 dout_ready  in  1  consumer accepts dout this cycle.
REQ-011 count  out  AW+1  occupied entries, 0..DEPTH.
REQ-012 overflow  out  1  sticky: a byte was dropped because the FIFO was full.
REQ-013 clr_overflow  in  1  clears overflow.

Function
REQ-014 Capture FSM SHALL have states IDLE, ACK, WAIT_CLR.
REQ-015 IDLE with rx_available=1 SHALL write rx_data (if not full) on that edge, set rx_ack=1, go to ACK.
REQ-016 ACK SHALL drive rx_ack=1 for exactly that one cycle, then go to WAIT_CLR.
REQ-017 WAIT_CLR SHALL drive rx_ack=0, stay while rx_available=1, and return to IDLE on the first cycle rx_available=0; no byte captured in ACK or WAIT_CLR.
REQ-018 Each byte presented SHALL be written at most once, even though rx_available stays high for two cycles after capture.
REQ-019 Latency: a byte written on edge N SHALL appear on dout with dout_valid=1 from cycle N+1 when the FIFO was empty.
REQ-020 Pop SHALL occur on an edge where dout_valid=1 and dout_ready=1; dout_ready while empty SHALL be ignored.
REQ-021 Full FIFO, capture without a simultaneous pop: byte SHALL be dropped, rx_ack still pulsed, overflow set to 1, contents unchanged.
REQ-022 Full FIFO, capture and pop on the same edge: both SHALL succeed, count stays DEPTH, overflow unchanged.
REQ-023 Simultaneous push and pop otherwise: count unchanged, both pointers advance.
REQ-024 Pointers SHALL be AW+1 bits, wrap modulo 2*DEPTH; full when MSBs differ and low bits equal, empty when all bits equal.
REQ-025 count SHALL equal wr_ptr - rd_ptr modulo 2^(AW+1).
REQ-026 clr_overflow SHALL clear overflow on the next edge; if an overflow drop coincides, overflow SHALL be 1 (set wins).
REQ-027 Order SHALL be preserved; no byte duplicated or reordered.

Reset
REQ-028 rst=1 SHALL force on the next edge: FSM=IDLE, rx_ack=0, pointers=0, count=0, dout_valid=0, overflow=0; memory contents need not clear.
REQ-029 rst SHALL override all other inputs, including mid-capture (ACK/WAIT_CLR): the in-flight byte is lost.
REQ-030 After rst deasserts with rx_available still 1, the FIFO SHALL capture that byte once (FSM restarts in IDLE).
REQ-031 dout SHALL read 8'h00 while dout_valid=0.

Structure
REQ-032 Shared package uart_pkg SHALL hold the capture FSM state encodings and the DEPTH default.
REQ-033 Storage and pointer logic SHALL live in one sub-module sync_fifo (push, pop, din, dout, full, empty, count); uart_rx_fifo holds the capture FSM and overflow flag.
REQ-034 Memory SHALL be a register array inferable as distributed RAM; no combinational path from rx_available to rx_ack.

Verification
REQ-035 Reset, then rx_data=8'hA5 held with rx_available high 3 cycles -> one rx_ack pulse, count=1, dout=8'hA5, dout_valid next cycle.
REQ-036 Push 8'h01..8'h10 (DEPTH=16), dout_ready=0 -> count=16, overflow=0; 17th byte 8'h11 -> rx_ack pulsed, overflow=1, count=16; drain -> 8'h01..8'h10 in order.
REQ-037 Full FIFO, dout_ready=1 held while 8'h55 captured -> count stays 16, overflow=0, 8'h55 last out.
REQ-038 overflow=1, clr_overflow pulsed alone -> overflow=0 next cycle; clr_overflow coincident with a dropped byte -> overflow=1.
REQ-039 rst asserted in ACK state with 3 bytes stored -> count=0, dout_valid=0, rx_ack=0 next cycle; rx_available still high after release -> exactly one capture.
REQ-040 Random 1000 bytes at rx_available spacing >=4 cycles, random dout_ready -> scoreboard match, count never exceeds 16, no duplicates.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive FIFO.
// Holds the capture FSM state encoding, the default FIFO depth and the
// byte width used by the receive path.
package uart_pkg;

  // Default number of FIFO entries. Must be a power of two and at least 2.
  localparam int DEPTH_DEF = 16;

  // Width of a received byte.
  localparam int DATA_W = 8;

  // Capture FSM states.
  //   CAP_IDLE     : waiting for the deserializer to present a byte
  //   CAP_ACK      : acknowledge pulse is on rx_ack for this one cycle
  //   CAP_WAIT_CLR : waiting for rx_available to drop before re-arming
  typedef enum logic [1:0] {
    CAP_IDLE     = 2'd0,
    CAP_ACK      = 2'd1,
    CAP_WAIT_CLR = 2'd2
  } cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO.
// Storage is a plain register array (distributed-RAM style, no reset on
// the data). Pointers carry one extra wrap bit so full and empty can be
// told apart without a separate occupancy counter.
//
// Ports
//   ser_ck : clock, all state updates on its rising edge
//   rst    : synchronous active-high reset of the pointers
//   push   : write din this edge (ignored when full unless popping too)
//   pop    : consume the head entry this edge (ignored when empty)
//   din    : write data
//   dout   : head entry, reads zero while empty
//   full   : all DEPTH entries occupied
//   empty  : no entries occupied
//   count  : occupied entries, 0..DEPTH
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              ser_ck,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign empty = (wr_ptr == rd_ptr);
  // Same slot but different lap: the writer is exactly one lap ahead.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd_en = pop & ~empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign wr_en = push & (~full | rd_en);

  // Modulo-2^(AW+1) difference is the occupancy directly.
  assign count = wr_ptr - rd_ptr;

  always_ff @(posedge ser_ck) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge ser_ck) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Fall-through read; force zero while empty so stale data never leaks.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive-side buffer.
// Takes bytes from a deserializer that holds rx_available high until it
// sees an acknowledge, stores them in a FWFT FIFO and reports drops.
//
// Ports
//   ser_ck       : sole clock
//   rst          : synchronous active-high reset
//   rx_data      : byte from the deserializer, valid while rx_available=1
//   rx_available : deserializer has a byte pending
//   rx_ack       : one-cycle pulse, byte consumed (to deserializer rd_data)
//   dout         : head-of-FIFO byte, zero while dout_valid=0
//   dout_valid   : FIFO not empty
//   dout_ready   : consumer takes dout this cycle
//   count        : occupied entries, 0..DEPTH
//   overflow     : sticky, a byte was dropped because the FIFO was full
//   clr_overflow : clears overflow (a coincident drop keeps it set)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        ser_ck,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_available,
  output logic        rx_ack,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [AW:0] count,
  output logic        overflow,
  input  logic        clr_overflow
);

  cap_state_t state;
  cap_state_t state_nxt;
  logic       capture;
  logic       fifo_full;
  logic       fifo_empty;
  logic       drop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .ser_ck (ser_ck),
    .rst    (rst),
    .push   (capture),
    .pop    (dout_ready),
    .din    (rx_data),
    .dout   (dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (count)
  );

  assign dout_valid = ~fifo_empty;

  // A full FIFO only loses the byte when nothing is popped on the same
  // edge; full implies non-empty, so dout_ready alone means a real pop.
  assign drop = capture & fifo_full & ~dout_ready;

  // Capture FSM: state register.
  always_ff @(posedge ser_ck) begin
    if (rst) state <= CAP_IDLE;
    else     state <= state_nxt;
  end

  // Capture FSM: next state. rx_available stays high for a couple of
  // cycles after the acknowledge, so the byte is only taken in IDLE and
  // IDLE is re-entered only once the level has dropped.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CAP_IDLE:     if (rx_available)  state_nxt = CAP_ACK;
      CAP_ACK:                         state_nxt = CAP_WAIT_CLR;
      CAP_WAIT_CLR: if (!rx_available) state_nxt = CAP_IDLE;
      default:                         state_nxt = CAP_IDLE;
    endcase
  end

  // Capture FSM: outputs. rx_ack depends on state only, never directly on
  // rx_available.
  always_comb begin
    rx_ack  = 1'b0;
    capture = 1'b0;
    unique case (state)
      CAP_IDLE: capture = rx_available;
      CAP_ACK:  rx_ack  = 1'b1;
      default: ;
    endcase
  end

  // Sticky drop flag; a drop on the same edge as a clear wins.
  always_ff @(posedge ser_ck) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios with literal expectations
// plus a queue-based reference model compared against the outputs on every
// cycle after the initial reset.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       ser_ck = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_available;
  logic       rx_ack;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [4:0] count;
  logic       overflow;
  logic       clr_overflow;

  int total  = 0;
  int passed = 0;
  bit chk_en    = 1'b0;
  bit rnd_ready = 1'b0;

  // Reference model state: queue of stored bytes and rule-level flags.
  logic [7:0] mq[$];
  bit m_ovf   = 1'b0;
  bit m_ack   = 1'b0;
  bit m_armed = 1'b1;  // a new byte may be taken
  bit m_hold  = 1'b0;  // the edge right after a capture never re-arms

  always #5 ser_ck = ~ser_ck;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .ser_ck       (ser_ck),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_available (rx_available),
    .rx_ack       (rx_ack),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: advance on each rising edge from the inputs.
  initial begin
    bit pop, cap, full, drop;
    forever begin
      @(posedge ser_ck);
      if (rst) begin
        mq.delete();
        m_ovf   = 1'b0;
        m_ack   = 1'b0;
        m_armed = 1'b1;
        m_hold  = 1'b0;
      end else begin
        pop  = (mq.size() != 0) && dout_ready;
        cap  = m_armed && rx_available;
        full = (mq.size() == DEPTH);
        drop = cap && full && !pop;
        if (pop) void'(mq.pop_front());
        if (cap && !drop) mq.push_back(rx_data);
        if (drop) m_ovf = 1'b1;
        else if (clr_overflow) m_ovf = 1'b0;
        m_ack = cap;
        if (cap) begin
          m_armed = 1'b0;
          m_hold  = 1'b1;
        end else if (m_hold) begin
          m_hold = 1'b0;
        end else if (!rx_available) begin
          m_armed = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge ser_ck) begin
    if (chk_en) begin
      chk("dout_valid", 32'(dout_valid), 32'(mq.size() != 0));
      chk("dout", 32'(dout), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      chk("count", 32'(count), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("rx_ack", 32'(rx_ack), 32'(m_ack));
    end
  end

  task automatic tick();
    @(posedge ser_ck);
    #1;
    if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
  endtask

  // Deserializer handshake: level held three cycles, then low for one.
  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_available = 1'b1;
    tick(); tick(); tick();
    rx_available = 1'b0;
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    rx_available = 1'b0;
    rx_data      = 8'h00;
    dout_ready   = 1'b0;
    clr_overflow = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_ack", 32'(rx_ack), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_dout", 32'(dout), 32'h00);
    rst = 1'b0;
    tick();

    // Single byte held for three cycles: one capture, one ack.
    rx_data = 8'hA5;
    rx_available = 1'b1;
    tick();
    chk("a5_ack", 32'(rx_ack), 32'd1);
    chk("a5_count", 32'(count), 32'd1);
    chk("a5_valid", 32'(dout_valid), 32'd1);
    chk("a5_dout", 32'(dout), 32'hA5);
    tick();
    chk("a5_ack_end", 32'(rx_ack), 32'd0);
    tick();
    rx_available = 1'b0;
    tick(); tick();
    chk("a5_once", 32'(count), 32'd1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("a5_popped", 32'(count), 32'd0);

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_ovf", 32'(overflow), 32'd0);
    send_byte(8'h11);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_count", 32'(count), 32'd16);
    dout_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", 32'(dout), 32'(i));
      tick();
    end
    dout_ready = 1'b0;
    chk("drain_empty", 32'(count), 32'd0);

    // Clear alone.
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr_alone", 32'(overflow), 32'd0);

    // Full FIFO, push and pop on the same edge.
    for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
    rx_data = 8'h55;
    rx_available = 1'b1;
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("pp_count", 32'(count), 32'd16);
    chk("pp_ovf", 32'(overflow), 32'd0);
    tick(); tick();
    rx_available = 1'b0;
    tick();
    dout_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("pp_order", 32'(dout), 32'(8'h20 + i));
      tick();
    end
    chk("pp_last", 32'(dout), 32'h55);
    tick();
    dout_ready = 1'b0;
    chk("pp_empty", 32'(dout_valid), 32'd0);

    // Clear coincident with a drop: set wins.
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
    rx_data = 8'h99;
    rx_available = 1'b1;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("set_wins", 32'(overflow), 32'd1);
    chk("set_count", 32'(count), 32'd16);
    tick(); tick();
    rx_available = 1'b0;
    tick();
    chk("contents_kept", 32'(dout), 32'h40);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("clr_after", 32'(overflow), 32'd0);

    // Reset in the ACK state, rx_available still high afterwards.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'(8'h60 + i));
    chk("pre_rst_count", 32'(count), 32'd3);
    rx_data = 8'h77;
    rx_available = 1'b1;
    tick();
    chk("in_ack", 32'(rx_ack), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_ack", 32'(rx_ack), 32'd0);
    tick();
    chk("recap_count", 32'(count), 32'd1);
    chk("recap_dout", 32'(dout), 32'h77);
    tick(); tick();
    rx_available = 1'b0;
    tick();
    chk("recap_once", 32'(count), 32'd1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;

    // Long run: 1000 bytes, random consumer.
    rnd_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      send_byte(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd_ready  = 1'b0;
    dout_ready = 1'b1;
    repeat (24) tick();
    chk("rand_drained", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
